// File: rtl/eth_pkt_fifo_ctrl.sv
// Store-and-forward packet controller for the eth_pkt_fifo RAM: buffers RX beats,
// exposes only complete error-free packets, and rewinds bad or oversized ones.
module eth_pkt_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH:0]   ram_rd_data,
    output logic                  pkt_drop,
    output logic [15:0]           drop_cnt,
    output logic [ADDR_WIDTH:0]   fill_level
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] wr_nxt, commit_nxt, wr_base;
    logic          full, wr_en, drop, rd_fire;

    assign full    = (wr_ptr - rd_ptr) == DEPTH;
    assign rd_fire = out_valid && out_ready;

    // wr_base is where this beat lands; an aborting sop restarts at commit_ptr.
    always_comb begin
        state_nxt  = state;
        wr_nxt     = wr_ptr;
        commit_nxt = commit_ptr;
        wr_base    = wr_ptr;
        wr_en      = 1'b0;
        drop       = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (in_sop) begin
                        if (full) begin
                            drop = 1'b1;
                            if (!in_eop) state_nxt = DROP;
                        end else if (in_eop) begin
                            if (in_err) begin
                                drop = 1'b1;
                            end else begin
                                wr_en      = 1'b1;
                                wr_nxt     = wr_ptr + 1'b1;
                                commit_nxt = wr_ptr + 1'b1;
                            end
                        end else begin
                            wr_en     = 1'b1;
                            wr_nxt    = wr_ptr + 1'b1;
                            state_nxt = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (full) begin
                        drop      = 1'b1;
                        wr_nxt    = commit_ptr;
                        state_nxt = in_eop ? IDLE : DROP;
                    end else begin
                        if (in_sop) begin
                            drop    = 1'b1;
                            wr_base = commit_ptr;
                        end
                        if (in_eop && in_err) begin
                            drop      = 1'b1;
                            wr_nxt    = commit_ptr;
                            state_nxt = IDLE;
                        end else begin
                            wr_en  = 1'b1;
                            wr_nxt = wr_base + 1'b1;
                            if (in_eop) begin
                                commit_nxt = wr_base + 1'b1;
                                state_nxt  = IDLE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (in_eop) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_drop   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_nxt;
            commit_ptr <= commit_nxt;
            pkt_drop   <= drop;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign ram_wr_en   = wr_en;
    assign ram_wr_addr = wr_base[ADDR_WIDTH-1:0];
    assign ram_wr_data = {in_eop, in_data};
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    assign out_valid  = rd_ptr != commit_ptr;
    assign out_data   = ram_rd_data[DATA_WIDTH-1:0];
    assign out_last   = ram_rd_data[DATA_WIDTH];
    assign fill_level = commit_ptr - rd_ptr;

endmodule

// File: tb/tb_eth_pkt_fifo_ctrl.sv
// Bench for eth_pkt_fifo_ctrl: acts as the RAM, keeps a packet-level reference
// model, and checks every cycle from a negedge monitor against a scoreboard queue.
module tb_eth_pkt_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid, in_sop, in_eop, in_err;
    logic [DW-1:0] out_data;
    logic          out_last, out_valid, out_ready;
    logic [DW:0]   ram_wr_data;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_wr_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW:0]   ram_rd_data;
    logic          pkt_drop;
    logic [15:0]   drop_cnt;
    logic [AW:0]   fill_level;

    always #5 clk = ~clk;

    eth_pkt_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .pkt_drop(pkt_drop), .drop_cnt(drop_cnt), .fill_level(fill_level)
    );

    logic [DW:0] mem [DEPTH];
    always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    assign ram_rd_data = mem[ram_rd_addr];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet under construction, committed-word scoreboard, counters.
    logic [DW-1:0] cur [$];
    logic [DW:0]   exp_q [$];
    bit  in_pkt, dropping;
    int  commit_total, drops_total, rd_done;
    int  commit_applied, drops_applied;
    bit  drop_now, pulse_exp, wr_exp;
    int  wadr_exp;
    logic [DW:0] wdat_exp;

    task automatic model_clear();
        cur.delete();
        exp_q.delete();
        in_pkt = 0; dropping = 0;
        commit_total = 0; drops_total = 0;
        drop_now = 0; wr_exp = 0;
    endtask

    task automatic commit_cur();
        for (int i = 0; i < cur.size(); i++)
            exp_q.push_back({(i == cur.size() - 1) ? 1'b1 : 1'b0, cur[i]});
        commit_total += cur.size();
        cur.delete();
        in_pkt = 0;
    endtask

    task automatic store(input logic [DW-1:0] d, input bit e);
        wr_exp   = 1;
        wadr_exp = (commit_total + cur.size()) % DEPTH;
        wdat_exp = {e, d};
        cur.push_back(d);
    endtask

    task automatic model_beat(input bit s, input bit e, input bit r, input logic [DW-1:0] d);
        bit full;
        full = ((commit_total - rd_done) + cur.size()) == DEPTH;
        if (dropping) begin
            if (e) dropping = 0;
        end else if (!in_pkt) begin
            if (s) begin
                if (full) begin
                    drop_now = 1;
                    dropping = !e;
                end else if (e && r) begin
                    drop_now = 1;
                end else begin
                    store(d, e);
                    in_pkt = 1;
                    if (e) commit_cur();
                end
            end
        end else if (full) begin
            drop_now = 1;
            cur.delete();
            in_pkt = 0;
            dropping = !e;
        end else begin
            if (s) begin
                drop_now = 1;
                cur.delete();
            end
            if (e && r) begin
                drop_now = 1;
                cur.delete();
                in_pkt = 0;
            end else begin
                store(d, e);
                if (e) commit_cur();
            end
        end
        if (drop_now && drops_total < 16'hFFFF) drops_total++;
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input bit r,
                         input logic [DW-1:0] d, input bit rdy);
        @(posedge clk); #1;
        commit_applied = commit_total;
        drops_applied  = drops_total;
        pulse_exp      = drop_now;
        drop_now = 0;
        wr_exp   = 0;
        rst = 1'b0;
        in_valid = v; in_sop = s; in_eop = e; in_err = r; in_data = d;
        out_ready = rdy;
        if (v) model_beat(s, e, r, d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_clear();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 8'h00, rdy);
    endtask

    task automatic send(input logic [DW-1:0] first, input int n, input bit err, input bit rdy);
        for (int i = 0; i < n; i++)
            drive(1, i == 0, i == n - 1, (i == n - 1) ? err : 1'b0, first + DW'(i), rdy);
    endtask

    // Monitor: state visible at this negedge reflects every edge so far; a read
    // flagged here happens at the coming posedge.
    always @(negedge clk) begin
        if (rst) begin
            rd_done = 0;
        end else begin
            chk("fill_level", 32'(fill_level), 32'(commit_applied - rd_done));
            chk("out_valid", 32'(out_valid), 32'((commit_applied - rd_done) != 0));
            chk("drop_cnt", 32'(drop_cnt), 32'(drops_applied));
            chk("pkt_drop", 32'(pkt_drop), 32'(pulse_exp));
            chk("ram_wr_en", 32'(ram_wr_en), 32'(wr_exp));
            if (wr_exp && ram_wr_en) begin
                chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wadr_exp));
                chk("ram_wr_data", 32'(ram_wr_data), 32'(wdat_exp));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("read_unexpected", 32'({out_last, out_data}), 32'h1FF);
                end else begin
                    chk("read_word", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
                rd_done++;
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_sop = 0; in_eop = 0; in_err = 0; in_data = '0; out_ready = 0;
        rd_done = 0; commit_applied = 0; drops_applied = 0; pulse_exp = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_clear();

        // Good packet held, then drained
        send(8'h10, 5, 0, 0);
        idle(3, 0);
        idle(8, 1);

        // Error-terminated packet followed by a good one
        send(8'h20, 4, 1, 0);
        send(8'hA0, 2, 0, 0);
        idle(5, 1);

        // Oversized packet with reader stalled, then a normal packet
        send(8'h40, 20, 0, 0);
        idle(2, 0);
        send(8'h70, 3, 0, 0);
        idle(6, 1);

        // Pointer wrap with continuous reading
        for (int k = 0; k < 40; k++) send(DW'(k * 3), 3, 0, 1);
        idle(5, 1);

        // Stray beat, then a packet missing its eop
        drive(1, 0, 0, 0, 8'h55, 1);
        drive(1, 1, 0, 0, 8'h01, 1);
        drive(1, 0, 0, 0, 8'h02, 1);
        drive(1, 1, 0, 0, 8'h03, 1);
        drive(1, 0, 1, 0, 8'h04, 1);
        idle(4, 1);

        // Reset with committed data and a packet in flight
        send(8'h80, 2, 0, 0);
        drive(1, 1, 0, 0, 8'h90, 0);
        drive(1, 0, 0, 0, 8'h91, 0);
        drive(1, 0, 0, 0, 8'h92, 0);
        do_reset();
        idle(1, 0);
        send(8'hC0, 3, 0, 1);
        idle(5, 1);

        // Randomized traffic: gaps, stray beats, errors, truncation, overflow
        begin
            bit force_long = 0;
            for (int p = 0; p < 250; p++) begin
                int len;
                bit err, trunc;
                len = $urandom_range(1, 6);
                if ($urandom_range(0, 19) == 0) len = $urandom_range(17, 20);
                if (force_long && len < 2) len = 2;
                err   = ($urandom_range(0, 7) == 0);
                trunc = (len >= 2) && ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0)
                    drive(1, 0, 0, 0, DW'($urandom), $urandom_range(0, 3) != 0);
                for (int i = 0; i < len; i++) begin
                    bit last;
                    last = (i == len - 1);
                    while ($urandom_range(0, 3) == 0)
                        drive(0, 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom),
                              $urandom_range(0, 3) != 0);
                    drive(1, i == 0, last && !trunc, last ? err : 1'($urandom),
                          DW'($urandom), $urandom_range(0, 3) != 0);
                end
                force_long = trunc;
            end
        end

        // Close any truncated packet, then drain everything
        drive(1, 0, 1, 0, 8'hEE, 1);
        idle(40, 1);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words left unread, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
